wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural register file at the far end of the writeback path: it consumes the writeback-select output (ALU result or load data) and commits it to the target register.
- Serves the decode stage with two combinational read ports. Includes write-to-read bypass so a same-cycle writeback is visible to decode.
- Holds a per-register pending-load scoreboard that raises a decode stall until an in-flight load's data has been written back.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- rs_addr  input  ADDR_W  read port A index (decode)
- rt_addr  input  ADDR_W  read port B index (decode)
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_en  input  1  writeback enable (RegWrite from MEM/WB)
- wb_addr  input  ADDR_W  writeback destination index
- wb_data  input  DATA_W  writeback data (writeback-select output)
- ld_issue  input  1  load instruction leaving decode this cycle
- ld_dest  input  ADDR_W  destination register of that load
- stall  output  1  decode must hold: a source register awaits load data
- pend_vec  output  NUM_REGS  scoreboard bits, one per register, for debug/verification

Behaviour:
- Reset is asynchronous and active-high.
  - All registers and all pend bits clear to 0 immediately on reset assertion.
  - rs_data = rt_data = 0, stall = 0 and pend_vec = 0 while reset is held.
  - Reset asserted mid-operation discards in-flight writes and pend bits. No write occurs on a clock edge while reset is high.
- Register 0:
  - Reads always return 0.
  - Writes to index 0 are ignored.
  - pend[0] never sets.
- Write: on rising edge, if wb_en=1 and wb_addr!=0, then reg[wb_addr] <= wb_data. Write latency is 1 cycle.
- Read: combinational. rs_data is derived as follows:
  - rs_addr==0 -> 0
  - else if wb_en and wb_addr==rs_addr -> wb_data (bypass)
  - else -> reg[rs_addr]
  - rt_data follows the same rule. Both ports may address the same register.
- Scoreboard, updated on rising edge:
  - Set: ld_issue=1 and ld_dest!=0 -> pend[ld_dest] <= 1.
  - Clear: wb_en=1 and wb_addr!=0 -> pend[wb_addr] <= 0.
  - Set and clear on the same index in the same cycle -> set wins; the newer load owns the register.
  - Set and clear on different indices -> both take effect.
  - Repeated set of an already pending register keeps it at 1. There is no count: a single writeback clears it.
- Stall (combinational):
  - stall = (rs_addr!=0 and pend[rs_addr] and not bypass_rs) or (rt_addr!=0 and pend[rt_addr] and not bypass_rt).
  - bypass_x = wb_en and wb_addr==x_addr.
  - So a writeback landing this cycle both delivers data and suppresses the stall for that operand.
- Width rules:
  - No arithmetic is performed.
  - Indices >= NUM_REGS cannot occur at the default parameters. For other parameter values, out-of-range reads return 0 and out-of-range writes are dropped.
- No handshake beyond stall. The upstream pipeline holds rs_addr/rt_addr and deasserts ld_issue while stall=1.

Decomposition:
- Shared package contents:
  - DATA_W, ADDR_W, NUM_REGS constants
  - typedef reg_idx_t (ADDR_W bits)
  - typedef word_t (DATA_W bits)
  - constant ZERO_REG = 0
- One natural sub-module: load_scoreboard.
  - Inputs: set/clear index and enable.
  - Outputs: pend vector and two lookup bits.
  - Instantiated once; the register array, bypass and zero handling stay in wb_regfile.

Test Plan:
1. Reset then read: assert reset mid-run after writing reg5=0x1234 -> rs_data(5)=0, pend_vec=0 immediately, without waiting for a clock edge. Deassert and read reg5 -> 0.
2. Write/read with bypass:
   - wb_en=1, wb_addr=7, wb_data=0xDEADBEEF, rs_addr=7 in the same cycle -> rs_data=0xDEADBEEF combinationally.
   - Next cycle with wb_en=0 -> still 0xDEADBEEF from the array.
3. Zero register: write wb_addr=0, wb_data=0xFFFFFFFF; ld_issue with ld_dest=0 -> rs_data(0)=0, pend_vec[0]=0, stall=0.
4. Load-use stall:
   - ld_issue=1, ld_dest=3; next cycle rt_addr=3 -> stall=1.
   - Stall stays 1 until the cycle wb_en=1, wb_addr=3, wb_data=0x55. In that cycle stall=0 and rt_data=0x55.
   - After that edge, pend_vec[3]=0.
5. Set/clear collision: pend[4]=1; same cycle ld_issue with ld_dest=4 and wb_en with wb_addr=4, wb_data=0x10 -> after the edge reg4=0x10 and pend_vec[4]=1, so a read of reg4 stalls.
6. Dual-port same index plus independent clear:
   - pend[9]=1; rs_addr=rt_addr=9 -> stall=1.
   - In the same cycle ld_issue with ld_dest=2 and wb with wb_addr=9 -> stall=0 this cycle; after the edge pend_vec[9]=0 and pend_vec[2]=1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback register file.
//   DATA_W    : register/data width
//   ADDR_W    : register index width
//   NUM_REGS  : number of architectural registers
//   reg_idx_t : register index type
//   word_t    : data word type
//   ZERO_REG  : index of the hard-wired zero register
package wb_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/wb_regfile_load_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load
// leaves decode and cleared when that register is written back.
// Index-zero filtering is the caller's job; this block only enforces
// range and set/clear priority.
// Ports:
//   i_clk, i_reset           : clock, async active-high reset
//   i_set_en, i_set_idx      : mark register as awaiting load data
//   i_clr_en, i_clr_idx      : writeback landed for this register
//   i_look_a_idx/i_look_b_idx: lookup indices
//   o_pend_vec               : full scoreboard
//   o_pend_a / o_pend_b      : scoreboard bit at each lookup index
module load_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_set_en,
  input  logic [ADDR_W-1:0]   i_set_idx,
  input  logic                i_clr_en,
  input  logic [ADDR_W-1:0]   i_clr_idx,
  input  logic [ADDR_W-1:0]   i_look_a_idx,
  input  logic [ADDR_W-1:0]   i_look_b_idx,
  output logic [NUM_REGS-1:0] o_pend_vec,
  output logic                o_pend_a,
  output logic                o_pend_b
);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_set_ok;
  logic                w_clr_ok;
  logic                w_a_ok;
  logic                w_b_ok;

  assign w_set_ok = (32'(i_set_idx)    < NUM_REGS);
  assign w_clr_ok = (32'(i_clr_idx)    < NUM_REGS);
  assign w_a_ok   = (32'(i_look_a_idx) < NUM_REGS);
  assign w_b_ok   = (32'(i_look_b_idx) < NUM_REGS);

  // Clear is applied before set so that a load issuing to the same
  // register as a landing writeback keeps the bit: the newer load owns it.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en && w_clr_ok) w_pend_nxt[i_clr_idx] = 1'b0;
    if (i_set_en && w_set_ok) w_pend_nxt[i_set_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_pend <= '0;
    else         r_pend <= w_pend_nxt;
  end

  assign o_pend_vec = r_pend;
  assign o_pend_a   = w_a_ok ? r_pend[i_look_a_idx] : 1'b0;
  assign o_pend_b   = w_b_ok ? r_pend[i_look_b_idx] : 1'b0;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the end of the writeback path.
// Two combinational read ports with write-to-read bypass, register 0
// hard-wired to zero, and a pending-load scoreboard driving a decode stall.
// Ports:
//   clk, reset        : clock, async active-high reset
//   rs_addr/rs_data   : read port A
//   rt_addr/rt_data   : read port B
//   wb_en/addr/data   : writeback commit
//   ld_issue/ld_dest  : load leaving decode, destination register
//   stall             : decode must hold
//   pend_vec          : scoreboard contents
//
// Flow control: there is no valid/ready pair. stall is the only
// backpressure; while it is 1 the upstream stage holds rs_addr/rt_addr
// and keeps ld_issue low. A writeback landing in the same cycle as a
// stalled read forwards its data and removes the stall for that operand.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs_addr,
  input  logic [ADDR_W-1:0]   rt_addr,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_dest,
  output logic                stall,
  output logic [NUM_REGS-1:0] pend_vec
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_rs_ok;
  logic              w_rt_ok;
  logic              w_wb_ok;
  logic              w_wr_en;
  logic              w_ld_set;
  logic              w_byp_rs;
  logic              w_byp_rt;
  logic              w_pend_rs;
  logic              w_pend_rt;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  assign w_rs_ok  = (32'(rs_addr) < NUM_REGS);
  assign w_rt_ok  = (32'(rt_addr) < NUM_REGS);
  assign w_wb_ok  = (32'(wb_addr) < NUM_REGS);

  assign w_wr_en  = wb_en && (wb_addr != ADDR_W'(ZERO_REG)) && w_wb_ok;
  assign w_ld_set = ld_issue && (ld_dest != ADDR_W'(ZERO_REG));

  assign w_byp_rs = wb_en && (wb_addr == rs_addr);
  assign w_byp_rt = wb_en && (wb_addr == rt_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Reads are forced to zero while reset is held so a writeback presented
  // during reset cannot leak through the bypass.
  always_comb begin
    w_rs_data = '0;
    if (!reset && (rs_addr != ADDR_W'(ZERO_REG)) && w_rs_ok) begin
      if (w_byp_rs) w_rs_data = wb_data;
      else          w_rs_data = r_regs[rs_addr];
    end
  end

  always_comb begin
    w_rt_data = '0;
    if (!reset && (rt_addr != ADDR_W'(ZERO_REG)) && w_rt_ok) begin
      if (w_byp_rt) w_rt_data = wb_data;
      else          w_rt_data = r_regs[rt_addr];
    end
  end

  load_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_load_scoreboard (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_set_en     (w_ld_set),
    .i_set_idx    (ld_dest),
    .i_clr_en     (w_wr_en),
    .i_clr_idx    (wb_addr),
    .i_look_a_idx (rs_addr),
    .i_look_b_idx (rt_addr),
    .o_pend_vec   (pend_vec),
    .o_pend_a     (w_pend_rs),
    .o_pend_b     (w_pend_rt)
  );

  assign rs_data = w_rs_data;
  assign rt_data = w_rt_data;
  assign stall   = ((rs_addr != ADDR_W'(ZERO_REG)) && w_pend_rs && !w_byp_rs) ||
                   ((rt_addr != ADDR_W'(ZERO_REG)) && w_pend_rt && !w_byp_rt);

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wb_addr, ld_dest;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en, ld_issue, stall;
  logic [31:0] pend_vec;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .ld_issue (ld_issue),
    .ld_dest  (ld_dest),
    .stall    (stall),
    .pend_vec (pend_vec)
  );

  // ---------------- scoreboard ----------------
  // mask bits: [3]=rs_data [2]=rt_data [1]=stall [0]=pend_vec
  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        stall;
    logic [31:0] pend;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;

  localparam logic [3:0] M_ALL = 4'b1111;
  localparam logic [3:0] M_RS  = 4'b1011;
  localparam logic [3:0] M_RT  = 4'b0111;
  localparam logic [3:0] M_SP  = 4'b0011;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_wben, input logic [4:0] a_wba,
                       input logic [31:0] a_wbd,
                       input logic a_ld, input logic [4:0] a_ldd);
    @(posedge clk);
    #1;
    rs_addr  = a_rs;
    rt_addr  = a_rt;
    wb_en    = a_wben;
    wb_addr  = a_wba;
    wb_data  = a_wbd;
    ld_issue = a_ld;
    ld_dest  = a_ldd;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] m,
                            input logic [31:0] e_rs, input logic [31:0] e_rt,
                            input logic e_stall, input logic [31:0] e_pend);
    exp_t e;
    e.mask  = m;
    e.rs    = e_rs;
    e.rt    = e_rt;
    e.stall = e_stall;
    e.pend  = e_pend;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  exp_t  mon_e;
  string mon_n;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      if (mon_e.mask[3]) begin
        checks++;
        if (rs_data !== mon_e.rs) begin
          fails++;
          $display("FAIL %s rs_data got=%h exp=%h", mon_n, rs_data, mon_e.rs);
        end
      end
      if (mon_e.mask[2]) begin
        checks++;
        if (rt_data !== mon_e.rt) begin
          fails++;
          $display("FAIL %s rt_data got=%h exp=%h", mon_n, rt_data, mon_e.rt);
        end
      end
      if (mon_e.mask[1]) begin
        checks++;
        if (stall !== mon_e.stall) begin
          fails++;
          $display("FAIL %s stall got=%b exp=%b", mon_n, stall, mon_e.stall);
        end
      end
      if (mon_e.mask[0]) begin
        checks++;
        if (pend_vec !== mon_e.pend) begin
          fails++;
          $display("FAIL %s pend_vec got=%h exp=%h", mon_n, pend_vec, mon_e.pend);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; rs_addr = '0; rt_addr = '0; wb_en = 1'b0; wb_addr = '0;
    wb_data = '0; ld_issue = 1'b0; ld_dest = '0;
    #1 reset = 1'b1;

    // reset state
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("reset_state", M_ALL, 32'h0, 32'h0, 1'b0, 32'h0);

    // write reg5, bypass visible immediately
    drive(5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    reset = 1'b0;
    expect_out("bypass5", M_RS, 32'h1234, 32'h0, 1'b0, 32'h0);

    // reg5 from array; issue load to reg6
    drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6);
    expect_out("array5", M_RS, 32'h1234, 32'h0, 1'b0, 32'h0);

    // reset mid-run with a write presented: outputs clear without an edge
    drive(5'd5, 5'd8, 1'b1, 5'd8, 32'hAA, 1'b0, 5'd0);
    reset = 1'b1;
    expect_out("reset_midrun", M_ALL, 32'h0, 32'h0, 1'b0, 32'h0);

    // after reset: reg5 lost, reg8 never written
    drive(5'd5, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    reset = 1'b0;
    expect_out("after_reset", M_ALL, 32'h0, 32'h0, 1'b0, 32'h0);

    // bypass then array read
    drive(5'd7, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
    expect_out("bypass7", M_ALL, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);
    drive(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("array7", M_RS, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);

    // zero register
    drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    expect_out("zero_bypass", M_ALL, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("zero_reg", M_ALL, 32'h0, 32'h0, 1'b0, 32'h0);

    // load-use stall on reg3
    drive(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    expect_out("ld_issue3", M_RS, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);
    drive(5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("load_use_stall", M_RT, 32'h0, 32'h0, 1'b1, 32'h8);
    drive(5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("stall_hold", M_SP, 32'h0, 32'h0, 1'b1, 32'h8);
    drive(5'd7, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    expect_out("wb_release", M_RT, 32'h0, 32'h55, 1'b0, 32'h8);
    drive(5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("pend3_clear", M_RT, 32'h0, 32'h55, 1'b0, 32'h0);

    // set/clear collision on reg4
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    expect_out("ld_issue4", M_SP, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h10, 1'b1, 5'd4);
    expect_out("collision", M_SP, 32'h0, 32'h0, 1'b0, 32'h10);
    drive(5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("collision_set_wins", M_RS, 32'h10, 32'h0, 1'b1, 32'h10);
    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'h10, 1'b0, 5'd0);
    expect_out("clear4", M_SP, 32'h0, 32'h0, 1'b0, 32'h10);

    // dual-port same index plus independent clear
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    expect_out("ld_issue9", M_SP, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("dual_stall", M_ALL, 32'h0, 32'h0, 1'b1, 32'h200);
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd2);
    expect_out("dual_bypass", M_ALL, 32'hCAFE, 32'hCAFE, 1'b0, 32'h200);
    drive(5'd9, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("indep_clear", M_ALL, 32'hCAFE, 32'h0, 1'b1, 32'h4);

    // repeated set then a single writeback clears
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    expect_out("reset_twice", M_SP, 32'h0, 32'h0, 1'b0, 32'h4);
    drive(5'd0, 5'd0, 1'b1, 5'd2, 32'h7, 1'b0, 5'd0);
    expect_out("wb2", M_SP, 32'h0, 32'h0, 1'b0, 32'h4);
    drive(5'd0, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expect_out("single_clear", M_RT, 32'h0, 32'h7, 1'b0, 32'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
